// File: rtl/vreg_commit_sequencer.sv
// Round-robin collector of vector-register writeback groups for the DPI monitor.
// Optional watchdog abort in COLLECT: define VREG_SEQ_TIMEOUT_EN.
module vreg_commit_sequencer #(
    parameter int VLEN           = 1024,
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ-1:0]      req_is_store,
    input  logic [NUM_REQ-1:0]      req_wr_rf,
    input  logic [8*NUM_REQ-1:0]    req_rf_addr,
    input  logic [8*NUM_REQ-1:0]    req_group_size,
    input  logic [VLEN*NUM_REQ-1:0] req_data,
    output logic                    mon_enable,
    output logic                    mon_is_store,
    output logic                    mon_wr_rf,
    output logic [7:0]              mon_rf_addr,
    output logic [7:0]              mon_rf_group_size,
    output logic [8*VLEN-1:0]       mon_data,
    output logic                    busy,
    output logic                    err_gsize,
    output logic                    err_timeout
);

    localparam int PW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, COLLECT, FIRE} state_t;

    if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("vreg_commit_sequencer: illegal parameter set");
    end

    state_t            state;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     owner;
    logic [PW-1:0]     gidx;
    logic [PW-1:0]     sel;
    logic [NUM_REQ-1:0] grant;
    logic              gfound;
    logic [3:0]        beat_cnt;
    logic              xfer;
    logic [VLEN-1:0]   sel_data;
    logic [7:0]        sel_size;
    logic              size_ok;

    function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
        return (int'(p) == NUM_REQ - 1) ? '0 : p + 1'b1;
    endfunction

    // first valid requester at or after the pointer, wrapping
    always_comb begin
        int idx;
        idx    = 0;
        grant  = '0;
        gidx   = ptr;
        gfound = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!gfound && req_valid[idx]) begin
                grant[idx] = 1'b1;
                gidx       = PW'(idx);
                gfound     = 1'b1;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        unique case (state)
            IDLE:    req_ready = grant;
            COLLECT: req_ready = NUM_REQ'(1) << owner;
            default: req_ready = '0;
        endcase
    end

    assign sel      = (state == IDLE) ? gidx : owner;
    assign sel_data = req_data[int'(sel)*VLEN +: VLEN];
    assign sel_size = req_group_size[int'(sel)*8 +: 8];
    assign size_ok  = sel_size inside {8'd1, 8'd2, 8'd4, 8'd8};
    assign xfer     = |(req_valid & req_ready);

`ifdef VREG_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle_cnt;
    logic          tmo_hit;

    assign tmo_hit = (state == COLLECT) && !xfer &&
                     (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            idle_cnt <= '0;
        else if (state == COLLECT && !xfer)
            idle_cnt <= idle_cnt + 1'b1;
        else
            idle_cnt <= '0;
    end
`else
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            ptr               <= '0;
            owner             <= '0;
            beat_cnt          <= '0;
            mon_enable        <= 1'b0;
            mon_is_store      <= 1'b0;
            mon_wr_rf         <= 1'b0;
            mon_rf_addr       <= '0;
            mon_rf_group_size <= '0;
            mon_data          <= '0;
            busy              <= 1'b0;
            err_gsize         <= 1'b0;
`ifdef VREG_SEQ_TIMEOUT_EN
            err_timeout       <= 1'b0;
`endif
        end else begin
            mon_enable <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (xfer) begin
                        mon_is_store      <= req_is_store[sel];
                        mon_wr_rf         <= req_wr_rf[sel];
                        mon_rf_addr       <= req_rf_addr[int'(sel)*8 +: 8];
                        mon_rf_group_size <= sel_size;
                        mon_data          <= {{(7*VLEN){1'b0}}, sel_data};
                        beat_cnt          <= 4'd1;
                        owner             <= gidx;
                        if (!size_ok) begin
                            err_gsize <= 1'b1;
                            ptr       <= inc_ptr(gidx);
                        end else if (sel_size == 8'd1) begin
                            state      <= FIRE;
                            mon_enable <= 1'b1;
                            busy       <= 1'b1;
                        end else begin
                            state <= COLLECT;
                            busy  <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (xfer) begin
                        mon_data[int'(beat_cnt[2:0])*VLEN +: VLEN] <= sel_data;
                        beat_cnt <= beat_cnt + 4'd1;
                        if ({4'd0, beat_cnt + 4'd1} == mon_rf_group_size) begin
                            state      <= FIRE;
                            mon_enable <= 1'b1;
                        end
                    end
`ifdef VREG_SEQ_TIMEOUT_EN
                    else if (tmo_hit) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        err_timeout <= 1'b1;
                        ptr         <= inc_ptr(owner);
                    end
`endif
                end
                FIRE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    ptr   <= inc_ptr(owner);
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/vreg_commit_sequencer.md
Name: vreg_commit_sequencer

Overview:
- Collects vector-register writeback groups from NUM_REQ requesters (vector execute writeback, store-data path) and delivers one complete register group per event to the get_vreg DPI monitor interface.
- Each group arrives as 1 to 8 beats, one VLEN-bit register per beat, over a valid/ready handshake.
- A round-robin arbiter locks onto one requester for the whole group. After the last beat, the block pulses mon_enable for one cycle with the assembled group.
- Sits between the vector backend writeback buses and the DPI monitor module.

Parameters:
- VLEN, 1024, vector register width in bits; must equal the monitor's VLEN.
- NUM_REQ, 2, number of requesters (range 2..4).
- TIMEOUT_CYCLES, 256, watchdog limit in cycles; used only when VREG_SEQ_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester beat valid
- req_ready  out  NUM_REQ  per-requester beat accept
- req_is_store  in  NUM_REQ  store flag, one bit per requester
- req_wr_rf  in  NUM_REQ  register-file-write flag, one bit per requester
- req_rf_addr  in  8*NUM_REQ  base register address; requester r at [r*8+:8]
- req_group_size  in  8*NUM_REQ  beats in the group; legal values 1, 2, 4, 8
- req_data  in  VLEN*NUM_REQ  beat data; requester r at [r*VLEN+:VLEN]
- mon_enable  out  1  one-cycle pulse: group complete
- mon_is_store  out  1  latched group header field
- mon_wr_rf  out  1  latched group header field
- mon_rf_addr  out  8  latched group header field
- mon_rf_group_size  out  8  latched group header field
- mon_data  out  8*VLEN  slot k at [k*VLEN+:VLEN]; k = beat index
- busy  out  1  high whenever state is not IDLE
- err_gsize  out  1  sticky: illegal group size seen
- err_timeout  out  1  sticky: watchdog abort (0 without the macro)

Behaviour:
- Reset:
  - Asynchronous, active-low.
  - State goes to IDLE; all outputs 0; mon_data 0; round-robin pointer 0; beat counter 0; sticky errors cleared.
  - Reset mid-group discards the partial group and no mon_enable is produced.
- A beat transfers when req_valid[r] and req_ready[r] are both high on a rising clk edge.
- req_ready is a function of registered state and req_valid only; it never depends on anything else combinationally.
- IDLE:
  - Round-robin grant starts at the pointer and picks the first requester with valid high.
  - req_ready is high only for the granted requester.
  - On transfer:
    - latch is_store, wr_rf, rf_addr and group_size from that beat;
    - clear slots 1..7 to 0 and write the data to slot 0;
    - set beat_cnt to 1 and record the owner.
  - Next state:
    - illegal size (0, 3, 5, 6, 7, or more than 8): set err_gsize, drop the group, stay in IDLE, advance the pointer;
    - size 1: go to FIRE;
    - otherwise: go to COLLECT.
- COLLECT:
  - req_ready is high only for the owner.
  - Each transfer writes slot[beat_cnt] and increments beat_cnt.
  - Header fields on later beats are ignored.
  - When beat_cnt+1 equals the latched size on a transfer, go to FIRE.
  - Other requesters are stalled, so groups never interleave.
- FIRE:
  - mon_enable = 1 for exactly one cycle; all req_ready are 0.
  - The pointer moves to owner+1 mod NUM_REQ; next state is IDLE.
- Timing:
  - mon_enable asserts the cycle after the last beat's transfer.
  - A G-beat group with no stalls occupies G+1 cycles.
  - The mon_* fields and mon_data hold their values until the next group header is accepted.
- rf_addr alignment is not checked; the value is passed through unchanged.
- Simultaneous valid in IDLE: exactly one grant; starvation-free, with at most NUM_REQ-1 groups of wait.

Optional Feature:
- Macro: VREG_SEQ_TIMEOUT_EN.
- When defined:
  - an idle counter runs in COLLECT, resets on every transfer, and increments otherwise;
  - when it reaches TIMEOUT_CYCLES, the group is aborted with no mon_enable, err_timeout is set, state returns to IDLE, and the pointer advances.
- When undefined: COLLECT waits indefinitely and err_timeout is tied to 0.

Test Plan:
- Req0 sends a group of size 4, addr 8, data A0..A3, back-to-back -> mon_enable one cycle after the 4th beat; mon_rf_addr=8; mon_rf_group_size=4; slots 0..3 = A0..A3; slots 4..7 = 0; 5 cycles total.
- Req0 and req1 both valid in IDLE with pointer 0, each sending size 2 -> req0's group fires first, then req1's; req1 stays stalled (ready 0) throughout req0's group.
- Req1 sends size 8 with valid dropped for 3 cycles between beats 4 and 5 -> single mon_enable after beat 8 with all 8 slots correct; req0 ready stays 0.
- Req0 header with group_size=3 -> err_gsize=1 and sticky; no mon_enable; a following legal size-1 group fires normally.
- rst_n asserted low after 2 of 4 beats -> all outputs 0 immediately; no mon_enable after release; next group is handled from IDLE.
- With VREG_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=16: size-2 group stalls after beat 1 -> abort after 16 idle cycles; err_timeout=1; no mon_enable.
